// File: rtl/rx_pkt_pkg.sv
// Shared types and defaults for the RX packet assembler.
// Holds the parser state encoding and counter sizing.
package rx_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         MAX_LEN_DEF   = 16;
  localparam int         CNT_W         = 8;
  localparam int         BUF_DEPTH     = 16;
  localparam int         ADDR_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK
  } rx_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pkt_buffer.sv
// Payload register file: async clear, sync write,
// combinational read.
module pkt_buffer
  import rx_pkt_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = BUF_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_packet_assembler.sv
// Parses SYNC/LEN/PAYLOAD/CHECK byte frames into a
// lockable payload buffer with good/bad/drop counters.
module rx_packet_assembler
  import rx_pkt_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         MAX_LEN   = MAX_LEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             error,
  input  logic             in_valid,
  input  logic [3:0]       rd_addr,
  input  logic             rd_release,
  output logic [7:0]       rd_data,
  output logic             pkt_done,
  output logic             pkt_ok,
  output logic [4:0]       pkt_len,
  output logic             buf_locked,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  rx_state_e        state_q, state_d;
  logic [4:0]       len_q, len_d;
  logic [4:0]       pkt_len_q, pkt_len_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic             err_seen_q, err_seen_d;
  logic             cap_q, cap_d;
  logic             pkt_done_q, pkt_done_d;
  logic             pkt_ok_q, pkt_ok_d;
  logic             buf_locked_q, buf_locked_d;
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic len_ok;
  logic last_byte;
  logic good;
  logic set_lock;
  logic buf_we;

  assign len_ok = !error
               && data_in >= 8'd1
               && data_in <= 8'(MAX_LEN);
  assign last_byte = ({1'b0, idx_q} == len_q - 5'd1);
  assign good = (data_in == csum_q)
             && !err_seen_q && !error;
  assign buf_we = in_valid
               && state_q == ST_PAYLOAD
               && !buf_locked_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pkt_len_d  = pkt_len_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    err_seen_d = err_seen_q;
    cap_d      = cap_q;
    pkt_done_d = 1'b0;
    pkt_ok_d   = 1'b0;
    ok_cnt_d   = ok_cnt_q;
    fail_cnt_d = fail_cnt_q;
    drop_cnt_d = drop_cnt_q;
    set_lock   = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (data_in == SYNC_BYTE && !error) begin
            state_d = ST_LEN;
          end
        end
        ST_LEN: begin
          if (len_ok) begin
            len_d      = data_in[4:0];
            idx_d      = '0;
            csum_d     = '0;
            err_seen_d = 1'b0;
            cap_d      = !buf_locked_q;
            state_d    = ST_PAYLOAD;
          end else begin
            fail_cnt_d = sat_inc(fail_cnt_q);
            state_d    = ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          csum_d     = csum_q ^ data_in;
          err_seen_d = err_seen_q | error;
          idx_d      = idx_q + 4'd1;
          if (last_byte) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          state_d    = ST_IDLE;
          pkt_done_d = 1'b1;
          pkt_ok_d   = good && cap_q;
          if (good && cap_q) begin
            set_lock  = 1'b1;
            pkt_len_d = len_q;
            ok_cnt_d  = sat_inc(ok_cnt_q);
          end else if (good) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
          end else begin
            fail_cnt_d = sat_inc(fail_cnt_q);
          end
        end
      endcase
    end
    // a fresh capture wins over any release seen with it
    buf_locked_d = set_lock
                | (buf_locked_q
                   & ~(rd_release & ~pkt_ok_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      pkt_len_q    <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
      err_seen_q   <= 1'b0;
      cap_q        <= 1'b0;
      pkt_done_q   <= 1'b0;
      pkt_ok_q     <= 1'b0;
      buf_locked_q <= 1'b0;
      ok_cnt_q     <= '0;
      fail_cnt_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      pkt_len_q    <= pkt_len_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      err_seen_q   <= err_seen_d;
      cap_q        <= cap_d;
      pkt_done_q   <= pkt_done_d;
      pkt_ok_q     <= pkt_ok_d;
      buf_locked_q <= buf_locked_d;
      ok_cnt_q     <= ok_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  pkt_buffer #(
    .DW    (8),
    .DEPTH (BUF_DEPTH),
    .AW    (ADDR_W)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (data_in),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign pkt_done   = pkt_done_q;
  assign pkt_ok     = pkt_ok_q;
  assign pkt_len    = pkt_len_q;
  assign buf_locked = buf_locked_q;
  assign ok_cnt     = ok_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
